// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - multi-channel switch debouncer with edge pulses and change-event handshake
//
// Purpose:
//   Each board switch is first brought into the clk domain by a 2-flop
//   synchronizer. A per-channel saturating counter then requires the new
//   level to stay stable before the debounced output follows it. Accepted
//   transitions produce one-cycle rise/fall pulses. The pulses are also
//   collected into a pending change mask, which a consumer drains with a
//   valid/ready handshake.
//
// Ports:
//   clk          in   rising-edge clock for all logic
//   rst          in   synchronous, active-high reset
//   sws_raw_i    in   [WIDTH] asynchronous raw switch levels
//   sws_db_o     out  [WIDTH] debounced switch levels
//   sws_rise_o   out  [WIDTH] one-cycle pulse on a debounced 0->1 change
//   sws_fall_o   out  [WIDTH] one-cycle pulse on a debounced 1->0 change
//   evt_valid_o  out  a change mask is pending
//   evt_ready_i  in   consumer accepts the pending mask
//   evt_mask_o   out  [WIDTH] accumulated changed channels
module switch_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sws_raw_i,
    output logic [WIDTH-1:0] sws_db_o,
    output logic [WIDTH-1:0] sws_rise_o,
    output logic [WIDTH-1:0] sws_fall_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [WIDTH-1:0] evt_mask_o
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] r_db;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_pend;

    logic             w_valid;
    logic [WIDTH-1:0] w_clr;

    // Synchronizer and per-channel debounce counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= sws_raw_i;
            r_sync2 <= r_sync1;
            r_rise  <= '0;
            r_fall  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    // Level agrees with the accepted one (including a bounce
                    // back), so any partial count is abandoned.
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_db[i]   <= r_sync2[i];
                    r_cnt[i]  <= '0;
                    r_rise[i] <= r_sync2[i];
                    r_fall[i] <= ~r_sync2[i];
                end else begin
                    // CNT_MAX is the terminal value, so this never wraps.
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Acknowledge clears only the bits that were visible to the consumer;
    // a change arriving in the same cycle is ORed back in and stays pending.
    assign w_valid = (r_pend != '0);
    assign w_clr   = (w_valid && evt_ready_i) ? r_pend : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | (r_rise | r_fall);
        end
    end

    assign sws_db_o    = r_db;
    assign sws_rise_o  = r_rise;
    assign sws_fall_o  = r_fall;
    assign evt_valid_o = w_valid;
    assign evt_mask_o  = r_pend;

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - directed self-checking bench for switch_debounce
module tb_switch_debounce;

    localparam int W  = 4;
    localparam int DC = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] sws_raw_i;
    logic [W-1:0] sws_db_o;
    logic [W-1:0] sws_rise_o;
    logic [W-1:0] sws_fall_o;
    logic         evt_valid_o;
    logic         evt_ready_i;
    logic [W-1:0] evt_mask_o;

    int total;
    int bad;

    switch_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sws_raw_i   (sws_raw_i),
        .sws_db_o    (sws_db_o),
        .sws_rise_o  (sws_rise_o),
        .sws_fall_o  (sws_fall_o),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_mask_o  (evt_mask_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_one;
        evt_ready_i = 1'b1;
        tick(1);
        evt_ready_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; sws_raw_i = '0; evt_ready_i = 1'b0;
        tick(2);
        total++;
        if (sws_db_o !== 4'b0000 || sws_rise_o !== 4'b0000 || sws_fall_o !== 4'b0000) begin
            bad++; $display("FAIL reset_outs: db=%b rise=%b fall=%b required 0000", sws_db_o, sws_rise_o, sws_fall_o);
        end
        total++;
        if (evt_valid_o !== 1'b0 || evt_mask_o !== 4'b0000) begin
            bad++; $display("FAIL reset_evt: valid=%b mask=%b required 0/0000", evt_valid_o, evt_mask_o);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_clean_step;
        sws_raw_i = 4'b0001;
        tick(9);
        total++;
        if (sws_db_o !== 4'b0000) begin
            bad++; $display("FAIL step_early: db=%b required 0000 after 9 edges", sws_db_o);
        end
        tick(1);
        total++;
        if (sws_db_o !== 4'b0001 || sws_rise_o !== 4'b0001 || sws_fall_o !== 4'b0000) begin
            bad++; $display("FAIL step_edge10: db=%b rise=%b fall=%b required 0001/0001/0000", sws_db_o, sws_rise_o, sws_fall_o);
        end
        tick(1);
        total++;
        if (sws_rise_o !== 4'b0000 || evt_valid_o !== 1'b1 || evt_mask_o !== 4'b0001) begin
            bad++; $display("FAIL step_event: rise=%b valid=%b mask=%b required 0000/1/0001", sws_rise_o, evt_valid_o, evt_mask_o);
        end
        ack_one();
        total++;
        if (evt_valid_o !== 1'b0 || evt_mask_o !== 4'b0000) begin
            bad++; $display("FAIL step_ack: valid=%b mask=%b required 0/0000", evt_valid_o, evt_mask_o);
        end
    endtask

    task automatic test_bounce;
        int rises;
        rises = 0;
        sws_raw_i = 4'b0011;
        for (int k = 0; k < 5; k++) begin tick(1); if (sws_rise_o[1]) rises++; end
        sws_raw_i = 4'b0001;
        for (int k = 0; k < 2; k++) begin tick(1); if (sws_rise_o[1]) rises++; end
        sws_raw_i = 4'b0011;
        for (int k = 0; k < 9; k++) begin tick(1); if (sws_rise_o[1]) rises++; end
        total++;
        if (sws_db_o !== 4'b0001) begin
            bad++; $display("FAIL bounce_early: db=%b required 0001", sws_db_o);
        end
        tick(1);
        if (sws_rise_o[1]) rises++;
        total++;
        if (sws_db_o !== 4'b0011 || sws_rise_o !== 4'b0010) begin
            bad++; $display("FAIL bounce_edge10: db=%b rise=%b required 0011/0010", sws_db_o, sws_rise_o);
        end
        for (int k = 0; k < 4; k++) begin tick(1); if (sws_rise_o[1]) rises++; end
        total++;
        if (rises !== 1) begin
            bad++; $display("FAIL bounce_pulses: count=%0d required 1", rises);
        end
        total++;
        if (evt_valid_o !== 1'b1 || evt_mask_o !== 4'b0010) begin
            bad++; $display("FAIL bounce_event: valid=%b mask=%b required 1/0010", evt_valid_o, evt_mask_o);
        end
        ack_one();
    endtask

    task automatic test_collision;
        sws_raw_i = 4'b0111;
        tick(12);
        ack_one();
        sws_raw_i = 4'b0110;
        tick(12);
        total++;
        if (evt_valid_o !== 1'b1 || evt_mask_o !== 4'b0001 || sws_db_o !== 4'b0110) begin
            bad++; $display("FAIL coll_setup: valid=%b mask=%b db=%b required 1/0001/0110", evt_valid_o, evt_mask_o, sws_db_o);
        end
        sws_raw_i = 4'b0010;
        tick(10);
        total++;
        if (sws_fall_o !== 4'b0100 || evt_mask_o !== 4'b0001) begin
            bad++; $display("FAIL coll_fall: fall=%b mask=%b required 0100/0001", sws_fall_o, evt_mask_o);
        end
        ack_one();
        total++;
        if (evt_valid_o !== 1'b1 || evt_mask_o !== 4'b0100) begin
            bad++; $display("FAIL coll_retain: valid=%b mask=%b required 1/0100", evt_valid_o, evt_mask_o);
        end
        tick(1);
        total++;
        if (evt_valid_o !== 1'b1 || evt_mask_o !== 4'b0100 || sws_fall_o !== 4'b0000) begin
            bad++; $display("FAIL coll_hold: valid=%b mask=%b fall=%b required 1/0100/0000", evt_valid_o, evt_mask_o, sws_fall_o);
        end
        ack_one();
    endtask

    task automatic test_accumulation;
        sws_raw_i = 4'b0011;
        tick(20);
        total++;
        if (evt_valid_o !== 1'b1 || evt_mask_o !== 4'b0001) begin
            bad++; $display("FAIL acc_first: valid=%b mask=%b required 1/0001", evt_valid_o, evt_mask_o);
        end
        sws_raw_i = 4'b1011;
        tick(12);
        total++;
        if (evt_valid_o !== 1'b1 || evt_mask_o !== 4'b1001 || sws_db_o !== 4'b1011) begin
            bad++; $display("FAIL acc_both: valid=%b mask=%b db=%b required 1/1001/1011", evt_valid_o, evt_mask_o, sws_db_o);
        end
        ack_one();
        total++;
        if (evt_valid_o !== 1'b0 || evt_mask_o !== 4'b0000) begin
            bad++; $display("FAIL acc_drain: valid=%b mask=%b required 0/0000", evt_valid_o, evt_mask_o);
        end
    endtask

    task automatic test_reset_mid;
        sws_raw_i = 4'b0000;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        sws_raw_i = 4'b0010;
        tick(7);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        total++;
        if (sws_db_o !== 4'b0000 || evt_valid_o !== 1'b0) begin
            bad++; $display("FAIL rmid_cleared: db=%b valid=%b required 0000/0", sws_db_o, evt_valid_o);
        end
        tick(9);
        total++;
        if (sws_db_o !== 4'b0000) begin
            bad++; $display("FAIL rmid_early: db=%b required 0000 after 9 edges", sws_db_o);
        end
        tick(1);
        total++;
        if (sws_db_o !== 4'b0010 || sws_rise_o !== 4'b0010) begin
            bad++; $display("FAIL rmid_edge10: db=%b rise=%b required 0010/0010", sws_db_o, sws_rise_o);
        end
        tick(1);
        total++;
        if (sws_rise_o !== 4'b0000 || evt_valid_o !== 1'b1 || evt_mask_o !== 4'b0010) begin
            bad++; $display("FAIL rmid_event: rise=%b valid=%b mask=%b required 0000/1/0010", sws_rise_o, evt_valid_o, evt_mask_o);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; sws_raw_i = '0; evt_ready_i = 1'b0;
        test_reset();
        test_clean_step();
        test_bounce();
        test_collision();
        test_accumulation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
